saturation_ctrl: RTL

SATURATION_CTRL -- requirements
Module: saturation_ctrl

---
 rtl/saturation_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/saturation_ctrl.sv
// -----------------------------------------------------------------------------
// saturation_ctrl
//
// Double-buffered coefficient controller for a saturation / luma filter.
// Software writes a pending coefficient set through a small register port,
// then pulses commit_i. The set is applied on the next frame start, which is
// the first sample of vs_i at its active level. Saturation then ramps toward
// its target by ramp_step on each following frame start.
//
// Ports
//   clk, rst        single rising-edge clock, asynchronous active-high reset
//   wr_i            register write strobe (one write per cycle)
//   addr_i[2:0]     0 sat_target, 1-3 ycoe0-2, 4 ramp_step, 5-7 read-only/reserved
//   wdata_i[15:0]   write data
//   rd_i            read strobe; rdata_o is valid one cycle later
//   rdata_o[15:0]   read data (5: {busy,armed,14'b0}, 6: frame_cnt, 7: saturation)
//   commit_i        one-cycle pulse that arms the pending set
//   vs_i            vertical sync of the video stream
//   saturation_o    active saturation (Q3.6)
//   ycoe0_o..2_o    active luma coefficients (Q3.6)
//   armed_o         a commit is pending and has not been applied yet
//   busy_o          armed or ramping
//   frame_cnt_o     frame-start counter, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module saturation_ctrl #(
  parameter bit          VS_POL    = 1'b1,
  parameter logic [15:0] SAT_RST   = 16'h0040,
  parameter logic [15:0] YCOE0_RST = 16'd19,
  parameter logic [15:0] YCOE1_RST = 16'd38,
  parameter logic [15:0] YCOE2_RST = 16'd7,
  parameter logic [15:0] FCNT_RST  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_i,
  input  logic [2:0]  addr_i,
  input  logic [15:0] wdata_i,
  input  logic        rd_i,
  output logic [15:0] rdata_o,
  input  logic        commit_i,
  input  logic        vs_i,
  output logic [15:0] saturation_o,
  output logic [15:0] ycoe0_o,
  output logic [15:0] ycoe1_o,
  output logic [15:0] ycoe2_o,
  output logic        armed_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RAMP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Pending (software-visible) set
  logic [15:0] r_p_target;
  logic [15:0] r_p_coe0;
  logic [15:0] r_p_coe1;
  logic [15:0] r_p_coe2;
  logic [15:0] r_p_step;

  // Active set
  logic [15:0] r_sat;
  logic [15:0] r_tgt;
  logic [15:0] r_step;
  logic [15:0] r_coe0;
  logic [15:0] r_coe1;
  logic [15:0] r_coe2;

  logic        r_vs_prev;
  logic [15:0] r_fcnt;
  logic        r_armed;
  logic        r_busy;
  logic [15:0] r_rdata;

  logic        w_fs;
  logic        w_apply;
  logic        w_ramp;
  logic [15:0] w_rt;
  logic [15:0] w_rs;
  logic [15:0] w_diff;
  logic        w_above;
  logic        w_reach;
  logic [15:0] w_sat_nxt;

  // Frame start: active level now, inactive at the previous sample.
  assign w_fs = (vs_i == VS_POL) && (r_vs_prev != VS_POL);

  // The applying frame already takes its first step, toward the newly
  // loaded target, so the step math reads the pending set while ARMED.
  assign w_rt    = (r_state == ST_ARMED) ? r_p_target : r_tgt;
  assign w_rs    = (r_state == ST_ARMED) ? r_p_step   : r_step;
  assign w_above = (r_sat > w_rt);
  assign w_diff  = w_above ? (r_sat - w_rt) : (w_rt - r_sat);
  assign w_reach = (w_rs == 16'd0) || (w_diff <= w_rs);
  // No overflow on the add: when not reaching, r_sat + w_rs < w_rt.
  assign w_sat_nxt = w_reach ? w_rt : (w_above ? (r_sat - w_rs) : (r_sat + w_rs));

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    w_ramp      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (commit_i) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_fs) begin
          w_apply     = 1'b1;
          // A commit on the applying edge re-arms for the following frame.
          w_state_nxt = commit_i ? ST_ARMED : ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (w_fs) begin
          w_ramp = 1'b1;
          if (commit_i)     w_state_nxt = ST_ARMED;
          else if (w_reach) w_state_nxt = ST_IDLE;
        end else if (commit_i) begin
          w_state_nxt = ST_ARMED;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= (w_state_nxt == ST_ARMED);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Pending registers, written from the register port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_target <= SAT_RST;
      r_p_coe0   <= YCOE0_RST;
      r_p_coe1   <= YCOE1_RST;
      r_p_coe2   <= YCOE2_RST;
      r_p_step   <= 16'd0;
    end else if (wr_i) begin
      case (addr_i)
        3'd0:    r_p_target <= wdata_i;
        3'd1:    r_p_coe0   <= wdata_i;
        3'd2:    r_p_coe1   <= wdata_i;
        3'd3:    r_p_coe2   <= wdata_i;
        3'd4:    r_p_step   <= wdata_i;
        default: ;
      endcase
    end
  end

  // Active set and frame bookkeeping; changes only on frame-start edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_prev <= ~VS_POL;
      r_fcnt    <= FCNT_RST;
      r_sat     <= SAT_RST;
      r_tgt     <= SAT_RST;
      r_step    <= 16'd0;
      r_coe0    <= YCOE0_RST;
      r_coe1    <= YCOE1_RST;
      r_coe2    <= YCOE2_RST;
    end else begin
      r_vs_prev <= vs_i;
      if (w_fs) r_fcnt <= r_fcnt + 16'd1;
      if (w_apply) begin
        r_tgt  <= r_p_target;
        r_step <= r_p_step;
        r_coe0 <= r_p_coe0;
        r_coe1 <= r_p_coe1;
        r_coe2 <= r_p_coe2;
      end
      if (w_apply || w_ramp) r_sat <= w_sat_nxt;
    end
  end

  // Registered read port; holds its last value when rd_i is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 16'd0;
    end else if (rd_i) begin
      case (addr_i)
        3'd0:    r_rdata <= r_p_target;
        3'd1:    r_rdata <= r_p_coe0;
        3'd2:    r_rdata <= r_p_coe1;
        3'd3:    r_rdata <= r_p_coe2;
        3'd4:    r_rdata <= r_p_step;
        3'd5:    r_rdata <= {r_busy, r_armed, 14'b0};
        3'd6:    r_rdata <= r_fcnt;
        default: r_rdata <= r_sat;
      endcase
    end
  end

  assign rdata_o      = r_rdata;
  assign saturation_o = r_sat;
  assign ycoe0_o      = r_coe0;
  assign ycoe1_o      = r_coe1;
  assign ycoe2_o      = r_coe2;
  assign armed_o      = r_armed;
  assign busy_o       = r_busy;
  assign frame_cnt_o  = r_fcnt;

endmodule
